// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, the sync/blank control word and its raster decode.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } vga_ctrl_t;

  // Sync windows are half-open: [start, end).
  function automatic vga_ctrl_t vga_decode(
    input logic [CNT_W-1:0] hcount,
    input logic [CNT_W-1:0] vcount,
    input logic [CNT_W-1:0] h_active,
    input logic [CNT_W-1:0] h_sync_start,
    input logic [CNT_W-1:0] h_sync_end,
    input logic [CNT_W-1:0] v_active,
    input logic [CNT_W-1:0] v_sync_start,
    input logic [CNT_W-1:0] v_sync_end,
    input logic             sync_pol
  );
    vga_ctrl_t ctrl;
    ctrl.hs      = (hcount >= h_sync_start && hcount < h_sync_end) ? sync_pol : ~sync_pol;
    ctrl.vs      = (vcount >= v_sync_start && vcount < v_sync_end) ? sync_pol : ~sync_pol;
    ctrl.blank_n = (hcount < h_active) && (vcount < v_active);
    return ctrl;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register with synchronous reset to a fixed idle value.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int  DEPTH     = 2,
  parameter type T         = vga_ctrl_t,
  parameter T    RESET_VAL = '0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ce_i,
  input  T     d_i,
  output T     q_o
);

  T stage_q [DEPTH];

  // NOTE: every stage is reset, not just the output, so no stale entry can reach q_o after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else if (ce_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: cascaded h/v counters, undelayed strobes, and sync/blank
// delayed through a shift register to line up with the pixel pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE      = VGA_H_ACTIVE,
  parameter int   H_FP          = VGA_H_FP,
  parameter int   H_SYNC        = VGA_H_SYNC,
  parameter int   H_BP          = VGA_H_BP,
  parameter int   V_ACTIVE      = VGA_V_ACTIVE,
  parameter int   V_FP          = VGA_V_FP,
  parameter int   V_SYNC        = VGA_V_SYNC,
  parameter int   V_BP          = VGA_V_BP,
  parameter logic SYNC_POL      = 1'b0,
  parameter int   PIXEL_LATENCY = 2
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             active,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank_start,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n,
  output logic             vga_sync_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACTIVE_C   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACTIVE_C   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam vga_ctrl_t CTRL_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, blank_n: 1'b0};

  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL=%0d does not fit the 10-bit counter", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL=%0d does not fit the 10-bit counter", V_TOTAL);
  end
  if (PIXEL_LATENCY < 1 || PIXEL_LATENCY > 4) begin : g_bad_latency
    $error("vga_timing_gen: PIXEL_LATENCY=%0d outside 1..4", PIXEL_LATENCY);
  end

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  vga_ctrl_t        ctrl_raw, ctrl_dly;

  // NOTE: next-state defaults to the current value first, so no path leaves a latch.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_ce) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign ctrl_raw = vga_decode(hcount_q, vcount_q, H_ACTIVE_C, H_SYNC_START, H_SYNC_END,
                               V_ACTIVE_C, V_SYNC_START, V_SYNC_END, SYNC_POL);

  vga_delay_line #(
    .DEPTH    (PIXEL_LATENCY),
    .T        (vga_ctrl_t),
    .RESET_VAL(CTRL_IDLE)
  ) u_ctrl_delay (
    .clk_i  (vga_clk),
    .reset_i(reset),
    .ce_i   (pix_ce),
    .d_i    (ctrl_raw),
    .q_o    (ctrl_dly)
  );

  // Strobes are qualified by pix_ce so a held counter value fires only once.
  assign line_start   = pix_ce && !reset && (hcount_q == '0);
  assign frame_start  = line_start && (vcount_q == '0);
  assign vblank_start = line_start && (vcount_q == V_ACTIVE_C);

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign active      = ctrl_raw.blank_n;
  assign vga_hs      = ctrl_dly.hs;
  assign vga_vs      = ctrl_dly.vs;
  assign vga_blank_n = ctrl_dly.blank_n;
  assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a reduced-timing instance for full-frame checks plus a default 640x480 instance.
module tb_vga_timing_gen;

  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;  // 25
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;  // 15
  localparam int LAT  = 2;

  localparam int P_HA [2] = '{S_HA, 640};
  localparam int P_HF [2] = '{S_HF, 16};
  localparam int P_HS [2] = '{S_HS, 96};
  localparam int P_HT [2] = '{S_HT, 800};
  localparam int P_VA [2] = '{S_VA, 480};
  localparam int P_VF [2] = '{S_VF, 10};
  localparam int P_VS [2] = '{S_VS, 2};
  localparam int P_VT [2] = '{S_VT, 525};

  localparam logic [2:0] PINS_IDLE = 3'b110;  // {hs, vs, blank_n}

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_ce = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] s_hc, s_vc, d_hc, d_vc;
  logic s_act, s_ls, s_fs, s_vb, s_hs, s_vs, s_bn, s_sn;
  logic d_act, d_ls, d_fs, d_vb, d_hs, d_vs, d_bn, d_sn;

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_POL(1'b0), .PIXEL_LATENCY(LAT)
  ) dut_small (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hcount(s_hc), .vcount(s_vc), .active(s_act),
    .line_start(s_ls), .frame_start(s_fs), .vblank_start(s_vb),
    .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank_n(s_bn), .vga_sync_n(s_sn)
  );

  vga_timing_gen dut_def (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hcount(d_hc), .vcount(d_vc), .active(d_act),
    .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vb),
    .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank_n(d_bn), .vga_sync_n(d_sn)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [2:0] ref_pins(input int id, input int h, input int v);
    logic hs_n, vs_n, bn;
    hs_n = !(h >= P_HA[id] + P_HF[id] && h < P_HA[id] + P_HF[id] + P_HS[id]);
    vs_n = !(v >= P_VA[id] + P_VF[id] && v < P_VA[id] + P_VF[id] + P_VS[id]);
    bn   = (h < P_HA[id]) && (v < P_VA[id]);
    return {hs_n, vs_n, bn};
  endfunction

  // Reference model: counters after the next edge, plus a queue of expected pin words.
  int mh [2];
  int mv [2];
  logic [2:0] sb0 [$];
  logic [2:0] sb1 [$];

  task automatic flush(input int id);
    mh[id] = 0;
    mv[id] = 0;
    if (id == 0) begin
      sb0.delete();
      repeat (LAT) sb0.push_back(PINS_IDLE);
    end else begin
      sb1.delete();
      repeat (LAT) sb1.push_back(PINS_IDLE);
    end
  endtask

  task automatic monitor(input int id, input logic [9:0] hc, input logic [9:0] vc,
                         input logic act, input logic ls, input logic fs, input logic vb,
                         input logic hs, input logic vs, input logic bn, input logic sn);
    logic [2:0] exp_pins;
    logic       exp_ls;
    exp_pins = (id == 0) ? sb0[0] : sb1[0];
    exp_ls   = pix_ce && !reset && (mh[id] == 0);
    check((id == 0) ? "cnt_small" : "cnt_def", 32'({hc, vc}), 32'({10'(mh[id]), 10'(mv[id])}));
    check((id == 0) ? "dec_small" : "dec_def", 32'({act, ls, fs, vb}),
          32'({(mh[id] < P_HA[id]) && (mv[id] < P_VA[id]), exp_ls,
               exp_ls && (mv[id] == 0), exp_ls && (mv[id] == P_VA[id])}));
    check((id == 0) ? "pins_small" : "pins_def", 32'({hs, vs, bn, sn}), 32'({exp_pins, 1'b0}));

    if (reset) begin
      flush(id);
    end else if (pix_ce) begin
      if (id == 0) begin
        sb0.push_back(ref_pins(id, mh[id], mv[id]));
        void'(sb0.pop_front());
      end else begin
        sb1.push_back(ref_pins(id, mh[id], mv[id]));
        void'(sb1.pop_front());
      end
      if (mh[id] == P_HT[id] - 1) begin
        mh[id] = 0;
        mv[id] = (mv[id] == P_VT[id] - 1) ? 0 : mv[id] + 1;
      end else begin
        mh[id] = mh[id] + 1;
      end
    end
  endtask

  // Per-frame measurements on the small instance; cpa = cycles per advance (0 = irregular).
  int cpa = 1;
  int last_cpa = 1;
  bit armed = 0;
  int cyc = 0, last_fs_cyc = 0;
  int blank_cyc = 0, vb_cnt = 0, hs_pulses = 0, vs_pulses = 0;
  int hs_run = 0, vs_run = 0, meas_frames = 0;

  always @(negedge clk) begin
    monitor(0, s_hc, s_vc, s_act, s_ls, s_fs, s_vb, s_hs, s_vs, s_bn, s_sn);
    monitor(1, d_hc, d_vc, d_act, d_ls, d_fs, d_vb, d_hs, d_vs, d_bn, d_sn);

    if (reset || cpa != last_cpa) begin
      armed  = 0;
      hs_run = 0;
      vs_run = 0;
    end
    last_cpa = cpa;
    if (s_fs) begin
      if (armed) begin
        check("frame_period", 32'(cyc - last_fs_cyc), 32'(S_HT * S_VT * cpa));
        check("blank_cycles", 32'(blank_cyc), 32'(S_HA * S_VA * cpa));
        check("hs_pulses", 32'(hs_pulses), 32'(S_VT));
        check("vs_pulses", 32'(vs_pulses), 32'd1);
        check("vblank_strobes", 32'(vb_cnt), 32'd1);
        meas_frames++;
      end
      armed       = (cpa != 0);
      last_fs_cyc = cyc;
      blank_cyc   = 0;
      vb_cnt      = 0;
      hs_pulses   = 0;
      vs_pulses   = 0;
    end
    if (armed) begin
      if (s_bn) blank_cyc++;
      if (s_vb) vb_cnt++;
      if (!s_hs) hs_run++;
      else if (hs_run > 0) begin
        check("hs_width", 32'(hs_run), 32'(S_HS * cpa));
        hs_pulses++;
        hs_run = 0;
      end
      if (!s_vs) vs_run++;
      else if (vs_run > 0) begin
        check("vs_width", 32'(vs_run), 32'(S_VS * S_HT * cpa));
        vs_pulses++;
        vs_run = 0;
      end
    end
    cyc++;
  end

  task automatic wait_pos(input int h, input int v, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 2 * S_HT * S_VT && !hit; i++) begin
      @(posedge clk); #1;
      hit = (mh[0] == h) && (mv[0] == v);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check({tag, "_cnt"}, 32'({s_hc, s_vc}), 32'd0);
    check({tag, "_pins"}, 32'({s_hs, s_vs, s_bn}), 32'(PINS_IDLE));
  endtask

  initial begin
    flush(0);
    flush(1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    repeat (2000) @(posedge clk);

    cpa = 2;
    for (int i = 0; i < 2400; i++) begin
      @(posedge clk); #1;
      pix_ce = ~pix_ce;
    end

    cpa = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      pix_ce = 1'($urandom_range(0, 1));
    end

    cpa = 1;
    pix_ce = 1'b1;
    wait_pos(10, 5, "reach_mid_frame");
    pulse_reset("rst_mid");
    repeat (200) @(posedge clk);
    #1;
    wait_pos(21, 2, "reach_hsync");
    pulse_reset("rst_hsync");
    repeat (800) @(posedge clk);
    #1;

    check("measured_frames", 32'(meas_frames >= 6), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
